// File: rtl/uart_tx_fifo_pkg.sv
// uart_pkg
//   Shared constants and types for the UART transmit FIFO slice.
//   UART_DATA_W          : byte width the RS-232 transmitter accepts
//   FIFO_DEPTH_LOG2_DEF  : default FIFO depth exponent (depth = 2**value)
//   issue_state_e        : issue FSM state encoding
package uart_pkg;

    localparam int UART_DATA_W         = 8;
    localparam int FIFO_DEPTH_LOG2_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } issue_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if
//   Bundles the bus-side push/status signals and the transmitter start/busy
//   handshake of uart_tx_fifo.
//   Bus side   : wr_en, wr_data, flush, ovf_clr (to FIFO);
//                full, empty, count, overflow (from FIFO)
//   Tx side    : tx_start, tx_data (to transmitter); tx_busy (from transmitter)
//   modport slave  : the uart_tx_fifo block
//   modport master : the environment (bus master plus transmitter)
interface uart_tx_fifo_if
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2_DEF,
    parameter int DATA_W     = UART_DATA_W
);

    logic                  wr_en;
    logic [DATA_W-1:0]     wr_data;
    logic                  flush;
    logic                  ovf_clr;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic                  tx_start;
    logic [DATA_W-1:0]     tx_data;
    logic                  tx_busy;

    modport slave (
        input  wr_en, wr_data, flush, ovf_clr, tx_busy,
        output full, empty, count, overflow, tx_start, tx_data
    );

    modport master (
        output wr_en, wr_data, flush, ovf_clr, tx_busy,
        input  full, empty, count, overflow, tx_start, tx_data
    );

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// sync_fifo
//   Circular byte buffer with separate occupancy counter and sticky overflow.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     wr_en_i      : push request; wr_data_i is the byte
//     rd_en_i      : pop request (caller only pops when not empty)
//     flush_i      : discard contents; beats any push or pop that cycle
//     ovf_clr_i    : clear sticky overflow (a same-cycle overflow event wins)
//     rd_data_o    : byte at the head of the queue
//     full_o, empty_o, count_o : occupancy status
//     overflow_o   : sticky, set by a push that had to be dropped
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2_DEF,
    parameter int DATA_W     = UART_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en_i,
    input  logic [DATA_W-1:0]   wr_data_i,
    input  logic                rd_en_i,
    input  logic                flush_i,
    input  logic                ovf_clr_i,
    output logic [DATA_W-1:0]   rd_data_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [DEPTH_LOG2:0] count_o,
    output logic                overflow_o
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q,  count_d;
    logic                  overflow_q, overflow_d;

    logic full, empty, push, pop, ovf_set;

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts
    // a push when the head is leaving. Flush suppresses both directions.
    assign pop     = rd_en_i & ~flush_i & ~empty;
    assign push    = wr_en_i & ~flush_i & (~full | pop);
    assign ovf_set = wr_en_i & ~flush_i & full & ~pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (ovf_clr_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o  = mem_q[rd_ptr_q];
    assign full_o     = full;
    assign empty_o    = empty;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte FIFO feeding the RS-232 transmitter through its start/busy handshake.
//   Ports:
//     clk  : single clock, all logic on posedge
//     rst  : synchronous active-high reset (transmitter itself is not reset)
//     bus  : uart_tx_fifo_if.slave
//            wr_en/wr_data/flush/ovf_clr in, full/empty/count/overflow out,
//            tx_start/tx_data out, tx_busy in
//
//   Issue FSM
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | wait for a queued byte and an idle transmitter, then pop it
//   ISSUE | tx_start high for exactly this cycle, tx_data holds the byte
//   HOLD  | transmitter busy is not valid yet; skip one cycle, back to IDLE
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2_DEF,
    parameter int DATA_W     = UART_DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_fifo_if.slave bus
);

    issue_state_e        state_q, state_d;
    logic                tx_start_q, tx_start_d;
    logic [DATA_W-1:0]   tx_data_q,  tx_data_d;

    logic                pop;
    logic [DATA_W-1:0]   head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [DEPTH_LOG2:0] fifo_count;
    logic                fifo_overflow;

    sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (bus.wr_en),
        .wr_data_i  (bus.wr_data),
        .rd_en_i    (pop),
        .flush_i    (bus.flush),
        .ovf_clr_i  (bus.ovf_clr),
        .rd_data_o  (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count),
        .overflow_o (fifo_overflow)
    );

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        pop        = 1'b0;

        case (state_q)
            IDLE: begin
                // Flush wins over a pending issue: the head is being discarded.
                if (!fifo_empty && !bus.tx_busy && !bus.flush) begin
                    pop        = 1'b1;
                    tx_data_d  = head;
                    tx_start_d = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                state_d = HOLD;
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.count    = fifo_count;
    assign bus.overflow = fifo_overflow;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int DL2    = 4;
    localparam int DW     = 8;
    localparam int DEPTH  = 16;
    localparam int TX_CYC = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DEPTH_LOG2(DL2), .DATA_W(DW)) bus ();

    uart_tx_fifo #(.DEPTH_LOG2(DL2), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    // Transmitter model: start honoured only while idle, busy from the next
    // cycle for TX_CYC cycles. Not affected by the FIFO reset.
    logic       model_busy = 1'b0;
    int         model_cnt  = 0;
    logic       hold_busy  = 1'b0;
    logic [7:0] model_byte = 8'h00;
    assign bus.tx_busy = model_busy | hold_busy;

    always @(posedge clk) begin
        if (model_busy) begin
            if (model_cnt == 1) model_busy <= 1'b0;
            model_cnt <= model_cnt - 1;
        end else if (bus.tx_start === 1'b1 && bus.tx_busy === 1'b0) begin
            model_busy <= 1'b1;
            model_cnt  <= TX_CYC;
            model_byte <= bus.tx_data;
        end
    end

    // Scoreboard: every start must meet an idle transmitter and the oldest
    // expected byte.
    always @(negedge clk) begin
        if (bus.tx_start === 1'b1) begin
            logic [7:0] e;
            n_checks++;
            if (bus.tx_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL start_while_busy: tx_busy=%b required 0 at %0t", bus.tx_busy, $time);
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_start: tx_data=%02h, required no start at %0t", bus.tx_data, $time);
            end else begin
                e = exp_q.pop_front();
                if (bus.tx_data !== e) begin
                    n_fail++;
                    $display("FAIL tx_data_order: got %02h required %02h at %0t", bus.tx_data, e, $time);
                end
            end
        end
    end

    task automatic drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && bus.empty === 1'b1 && bus.tx_busy === 1'b0 && bus.tx_start !== 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (TX_CYC + 4) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.wr_en = 0; bus.wr_data = '0; bus.flush = 0; bus.ovf_clr = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.count !== 5'd0)    begin n_fail++; $display("FAIL rst_count: got %0d required 0", bus.count); end
        n_checks++; if (bus.empty !== 1'b1)    begin n_fail++; $display("FAIL rst_empty: got %b required 1", bus.empty); end
        n_checks++; if (bus.full !== 1'b0)     begin n_fail++; $display("FAIL rst_full: got %b required 0", bus.full); end
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b required 0", bus.overflow); end
        n_checks++; if (bus.tx_start !== 1'b0) begin n_fail++; $display("FAIL rst_tx_start: got %b required 0", bus.tx_start); end
        n_checks++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %02h required 00", bus.tx_data); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        bit ok;
        exp_q.push_back(8'h55);
        bus.wr_en = 1; bus.wr_data = 8'h55;
        @(negedge clk);
        bus.wr_en = 0;
        n_checks++; if (bus.count !== 5'd1) begin n_fail++; $display("FAIL single_count_after_push: got %0d required 1", bus.count); end
        @(negedge clk);
        n_checks++; if (bus.tx_start !== 1'b1) begin n_fail++; $display("FAIL single_latency: tx_start got %b required 1", bus.tx_start); end
        n_checks++; if (bus.tx_data !== 8'h55) begin n_fail++; $display("FAIL single_tx_data: got %02h required 55", bus.tx_data); end
        n_checks++; if (bus.empty !== 1'b1)    begin n_fail++; $display("FAIL single_empty: got %b required 1", bus.empty); end
        n_checks++; if (bus.count !== 5'd0)    begin n_fail++; $display("FAIL single_count: got %0d required 0", bus.count); end
        drain(500, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_drain: timeout, %0d bytes outstanding", exp_q.size()); end
    endtask

    task automatic test_fill_overflow();
        bit ok;
        hold_busy = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= DEPTH; i++) begin
            exp_q.push_back(8'(i));
            bus.wr_en = 1; bus.wr_data = 8'(i);
            @(negedge clk);
        end
        bus.wr_en = 0;
        n_checks++; if (bus.full !== 1'b1)      begin n_fail++; $display("FAIL fill_full: got %b required 1", bus.full); end
        n_checks++; if (bus.count !== 5'd16)    begin n_fail++; $display("FAIL fill_count: got %0d required 16", bus.count); end
        n_checks++; if (bus.overflow !== 1'b0)  begin n_fail++; $display("FAIL fill_no_overflow: got %b required 0", bus.overflow); end
        // 17th push is dropped
        bus.wr_en = 1; bus.wr_data = 8'h99;
        @(negedge clk);
        bus.wr_en = 0;
        n_checks++; if (bus.overflow !== 1'b1)  begin n_fail++; $display("FAIL ovf_set: got %b required 1", bus.overflow); end
        n_checks++; if (bus.count !== 5'd16)    begin n_fail++; $display("FAIL ovf_count: got %0d required 16", bus.count); end
        // clear together with another overflowing push: set wins
        bus.ovf_clr = 1; bus.wr_en = 1; bus.wr_data = 8'h98;
        @(negedge clk);
        bus.wr_en = 0;
        n_checks++; if (bus.overflow !== 1'b1)  begin n_fail++; $display("FAIL ovf_set_wins: got %b required 1", bus.overflow); end
        @(negedge clk);
        bus.ovf_clr = 0;
        n_checks++; if (bus.overflow !== 1'b0)  begin n_fail++; $display("FAIL ovf_clr: got %b required 0", bus.overflow); end
        // release busy: the issue pop and a push of 0xAA share one cycle
        hold_busy = 1'b0;
        exp_q.push_back(8'hAA);
        bus.wr_en = 1; bus.wr_data = 8'hAA;
        @(negedge clk);
        bus.wr_en = 0;
        n_checks++; if (bus.count !== 5'd16)    begin n_fail++; $display("FAIL pushpop_count: got %0d required 16", bus.count); end
        n_checks++; if (bus.overflow !== 1'b0)  begin n_fail++; $display("FAIL pushpop_overflow: got %b required 0", bus.overflow); end
        n_checks++; if (bus.tx_start !== 1'b1)  begin n_fail++; $display("FAIL pushpop_issue: tx_start got %b required 1", bus.tx_start); end
        drain(3000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL fill_drain: timeout, %0d bytes outstanding", exp_q.size()); end
    endtask

    task automatic test_flush();
        bit ok;
        hold_busy = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus.wr_en = 1; bus.wr_data = 8'h21 + 8'(i);
            @(negedge clk);
        end
        bus.wr_en = 0;
        n_checks++; if (bus.count !== 5'd3) begin n_fail++; $display("FAIL flush_precount: got %0d required 3", bus.count); end
        hold_busy = 1'b0; bus.flush = 1;
        @(negedge clk);
        bus.flush = 0;
        n_checks++; if (bus.tx_start !== 1'b0) begin n_fail++; $display("FAIL flush_no_start: got %b required 0", bus.tx_start); end
        n_checks++; if (bus.count !== 5'd0)    begin n_fail++; $display("FAIL flush_count: got %0d required 0", bus.count); end
        n_checks++; if (bus.empty !== 1'b1)    begin n_fail++; $display("FAIL flush_empty: got %b required 1", bus.empty); end
        repeat (5) @(negedge clk);
        exp_q.push_back(8'h7E);
        bus.wr_en = 1; bus.wr_data = 8'h7E;
        @(negedge clk);
        bus.wr_en = 0;
        drain(500, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL flush_drain: timeout, %0d bytes outstanding", exp_q.size()); end
    endtask

    task automatic test_reset_mid_byte();
        bit ok;
        exp_q.push_back(8'hA5);
        bus.wr_en = 1; bus.wr_data = 8'hA5;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            bus.wr_en = 1; bus.wr_data = 8'h31 + 8'(i);
            @(negedge clk);
        end
        bus.wr_en = 0;
        n_checks++; if (bus.count !== 5'd5)    begin n_fail++; $display("FAIL mid_precount: got %0d required 5", bus.count); end
        n_checks++; if (bus.tx_busy !== 1'b1)  begin n_fail++; $display("FAIL mid_tx_running: tx_busy got %b required 1", bus.tx_busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (bus.count !== 5'd0)    begin n_fail++; $display("FAIL mid_rst_count: got %0d required 0", bus.count); end
        n_checks++; if (bus.empty !== 1'b1)    begin n_fail++; $display("FAIL mid_rst_empty: got %b required 1", bus.empty); end
        n_checks++; if (bus.tx_start !== 1'b0) begin n_fail++; $display("FAIL mid_rst_tx_start: got %b required 0", bus.tx_start); end
        n_checks++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL mid_rst_tx_data: got %02h required 00", bus.tx_data); end
        // push while the transmitter is still busy; start must wait for it
        exp_q.push_back(8'h3C);
        bus.wr_en = 1; bus.wr_data = 8'h3C;
        @(negedge clk);
        bus.wr_en = 0;
        n_checks++; if (bus.tx_start !== 1'b0) begin n_fail++; $display("FAIL mid_wait_busy: tx_start got %b required 0", bus.tx_start); end
        drain(500, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL mid_drain: timeout, %0d bytes outstanding", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        for (int i = 0; i < 10; i++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            bus.wr_en = 1; bus.wr_data = b;
            @(negedge clk);
            bus.wr_en = 0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain(3000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_drain: timeout, %0d bytes outstanding", exp_q.size()); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_flush();
        test_reset_mid_byte();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: %0d bytes never issued, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
